// File: rtl/spi_imu_reader.sv
// SPI mode-0 master that reads a burst of NUM_CH words from an IMU into a tear-free output register.
// Optional trailing checksum byte is enabled with the SPI_IMU_CHECKSUM_EN macro.
//
// state   | meaning
// IDLE    | waiting for start, ss high
// SETUP   | ss low, CLK_DIV cycles of sck low before the first edge
// CMD     | shifting the command byte out on mosi
// DATA    | shifting NUM_CH*DATA_W bits in from miso
// CHK     | shifting the checksum byte in (checksum build only)
// GAP     | ss high recovery time; first cycle carries done
module spi_imu_reader #(
  parameter int NUM_CH  = 9,
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [7:0]               cmd,
  output logic                     busy,
  output logic                     done,
  output logic                     chk_err,
  output logic [NUM_CH*DATA_W-1:0] data_flat,
  output logic                     sck,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     ss
);

  localparam int TW = NUM_CH * DATA_W;
  localparam int CW = $clog2(((CLK_DIV > GAP) ? CLK_DIV : GAP) + 1);
  localparam int BW = $clog2(((DATA_W > 8) ? DATA_W : 8) + 1);
  localparam int WW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_DATA, S_CHK, S_GAP} state_t;

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_left;
  logic [WW-1:0] word_cnt;
  logic [7:0] cmd_sr;
  logic [DATA_W-2:0] word_sr;
  logic [TW-1:0] shadow;
  logic sck_q, shifting, tc, rise, fall, bit_last, word_last, commit, commit_ok;

  assign tc        = (cnt == '0);
  assign shifting  = state inside {S_CMD, S_DATA, S_CHK};
  assign rise      = shifting && !sck_q && tc;
  assign fall      = shifting && sck_q && tc;
  assign bit_last  = (bit_left == BW'(1));
  assign word_last = (word_cnt == WW'(NUM_CH - 1));
  assign commit    = (state_nx == S_GAP) && (state != S_GAP);
  assign sck       = sck_q;

  always_ff @(posedge clock) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SETUP;
      S_SETUP: if (tc) state_nx = S_CMD;
      S_CMD:   if (fall && bit_last) state_nx = S_DATA;
      S_DATA:
        if (fall && bit_last && word_last)
`ifdef SPI_IMU_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_GAP;
`endif
      S_CHK:   if (fall && bit_last) state_nx = S_GAP;
      S_GAP:   if (tc) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    ss   = !(state inside {S_SETUP, S_CMD, S_DATA, S_CHK});
    mosi = (state == S_SETUP || state == S_CMD) ? cmd_sr[7] : 1'b0;
    done = (state == S_GAP) && (cnt == CW'(GAP - 1));
  end

  // One down-counter times both the sck half-periods and the GAP hold-off.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= '0;
      sck_q    <= 1'b0;
      bit_left <= '0;
      word_cnt <= '0;
      cmd_sr   <= '0;
      word_sr  <= '0;
      shadow   <= '0;
    end else begin
      if (commit)                 cnt <= CW'(GAP - 1);
      else if (state == S_IDLE || tc) cnt <= CW'(CLK_DIV - 1);
      else                        cnt <= cnt - CW'(1);

      if (rise)      sck_q <= 1'b1;
      else if (fall) sck_q <= 1'b0;

      if (state == S_IDLE && start) begin
        cmd_sr   <= cmd;
        bit_left <= BW'(8);
        word_cnt <= '0;
      end

      if (fall) begin
        if (state == S_CMD) cmd_sr <= {cmd_sr[6:0], 1'b0};
        if (!bit_last)
          bit_left <= bit_left - BW'(1);
        else if (state == S_CMD || (state == S_DATA && !word_last))
          bit_left <= BW'(DATA_W);
        else
          bit_left <= BW'(8);
        if (state == S_DATA && bit_last) word_cnt <= word_last ? '0 : word_cnt + WW'(1);
      end

      if (rise && state != S_CMD) word_sr <= {word_sr[DATA_W-3:0], miso};
      if (rise && state == S_DATA && bit_last)
        shadow[word_cnt*DATA_W +: DATA_W] <= {word_sr, miso};
    end
  end

`ifdef SPI_IMU_CHECKSUM_EN
  logic [7:0] sum;
  logic chk_ok, chk_err_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sum       <= '0;
      chk_ok    <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      if (state == S_IDLE && start) sum <= '0;
      else if (rise && state == S_DATA && bit_left[2:0] == 3'd1) sum <= sum + {word_sr[6:0], miso};
      if (rise && state == S_CHK && bit_last) chk_ok <= ({word_sr[6:0], miso} == sum);
      if (commit) chk_err_q <= !chk_ok;
    end
  end

  assign chk_err   = chk_err_q;
  assign commit_ok = commit && chk_ok;
`else
  assign chk_err   = 1'b0;
  assign commit_ok = commit;
`endif

  always_ff @(posedge clock) begin
    if (!reset)         data_flat <= '0;
    else if (commit_ok) data_flat <= shadow;
  end

endmodule

// File: tb/tb_spi_imu_reader.sv
// Self-checking bench for spi_imu_reader: a small 2x16 instance and a default-parameter instance,
// each talking to a behavioural mode-0 SPI slave.
module tb_spi_imu_reader;

  localparam int CD_A = 2, G_A = 4;
  localparam int CD_D = 4, G_D = 8;
`ifdef SPI_IMU_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clock = 1'b0, reset = 1'b0, start_a = 1'b0, start_d = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic busy_a, done_a, err_a, sck_a, mosi_a, ss_a;
  logic busy_d, done_d, err_d, sck_d, mosi_d, ss_d;
  logic miso_a = 1'b0, miso_d = 1'b0;
  logic [31:0]  data_a;
  logic [143:0] data_d;
  logic [31:0]  model_a = '0;
  logic [143:0] model_d = '0;
  int n_chk = 0, n_fail = 0;

  always #5 clock = ~clock;

  spi_imu_reader #(.NUM_CH(2), .DATA_W(16), .CLK_DIV(CD_A), .GAP(G_A)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .cmd(cmd), .busy(busy_a), .done(done_a),
    .chk_err(err_a), .data_flat(data_a), .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .ss(ss_a));

  spi_imu_reader dut_d (
    .clock(clock), .reset(reset), .start(start_d), .cmd(cmd), .busy(busy_d), .done(done_d),
    .chk_err(err_d), .data_flat(data_d), .sck(sck_d), .mosi(mosi_d), .miso(miso_d), .ss(ss_d));

  // Slave streams: byte 0 fills the command slot, then data bytes, then the checksum byte.
  logic [7:0] qa[$];
  logic [7:0] qd[$];

  function automatic logic sbit(input bit sel, input int i);
    logic [7:0] b;
    int n;
    n = i / 8;
    if (sel) b = (n < qd.size()) ? qd[n] : 8'h00;
    else     b = (n < qa.size()) ? qa[n] : 8'h00;
    return b[7 - (i % 8)];
  endfunction

  int ia = 0, rca = 0, id = 0, rcd = 0;
  logic [7:0] ra = '0, rd = '0;
  logic psa = 1'b0, psd = 1'b0;

  always @(ss_a, sck_a) begin
    if (ss_a) begin ia = 0; rca = 0; end
    else if (sck_a && !psa) begin if (rca < 8) begin ra = {ra[6:0], mosi_a}; rca++; end end
    else if (!sck_a && psa) ia++;
    psa = sck_a;
    miso_a = sbit(1'b0, ia);
  end

  always @(ss_d, sck_d) begin
    if (ss_d) begin id = 0; rcd = 0; end
    else if (sck_d && !psd) begin if (rcd < 8) begin rd = {rd[6:0], mosi_d}; rcd++; end end
    else if (!sck_d && psd) id++;
    psd = sck_d;
    miso_d = sbit(1'b1, id);
  end

  function automatic int latency(input int n_words, input int cd);
    return 1 + cd + 2 * cd * (8 + n_words * 16 + 8 * CHK);
  endfunction

  function automatic logic [143:0] cur_data(input bit sel);
    return sel ? data_d : {112'b0, data_a};
  endfunction

  // Words are w[31:16] then w[15:0]; the channel-0 word lands in the low half.
  task automatic load_a(input logic [31:0] w, input bit bad, output logic [31:0] nd);
    logic [7:0] s;
    s = 8'h00;
    qa.delete();
    qa.push_back(8'h00);
    for (int i = 0; i < 4; i++) begin
      qa.push_back(w[31 - 8*i -: 8]);
      s = s + w[31 - 8*i -: 8];
    end
    qa.push_back(bad ? s + 8'h01 : s);
    nd = {w[15:0], w[31:16]};
  endtask

  task automatic run_burst(input bit sel, input logic [7:0] c, input logic [143:0] exp_data,
                           input bit exp_err, input logic [143:0] prev, input int p1, input int p2);
    int lat, gap, cyc, done_at, done_cnt, ss_hi;
    bit first_ok, rise_ok, torn, fin;
    logic b, d, s, prev_ss;
    lat = sel ? latency(9, CD_D) : latency(2, CD_A);
    gap = sel ? G_D : G_A;
    done_at = -1; done_cnt = 0; ss_hi = 0;
    first_ok = 0; rise_ok = 0; torn = 0; fin = 0; prev_ss = 1'b1;
    cmd = c;
    if (sel) start_d = 1'b1; else start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_d = 1'b0;
    for (cyc = 1; cyc <= lat + gap + 20; cyc++) begin
      @(negedge clock);
      b = sel ? busy_d : busy_a;
      d = sel ? done_d : done_a;
      s = sel ? ss_d : ss_a;
      if (cyc == 1) first_ok = (s === 1'b0 && b === 1'b1);
      if (d === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin done_at = cyc; rise_ok = (s === 1'b1 && prev_ss === 1'b0); end
      end
      if (done_at < 0 && cur_data(sel) !== prev) torn = 1;
      if (done_at >= 0 && s === 1'b1) ss_hi++;
      prev_ss = s;
      if (done_at >= 0 && b === 1'b0) begin fin = 1; break; end
      if (cyc == p1 || cyc == p2) begin if (sel) start_d = 1'b1; else start_a = 1'b1; end
      @(posedge clock); #1;
      start_a = 1'b0; start_d = 1'b0;
    end
    n_chk++; if (!fin) begin n_fail++; $display("FAIL burst_timeout: cycles=%0d limit=%0d", cyc, lat + gap + 20); end
    n_chk++; if (!first_ok) begin n_fail++; $display("FAIL ss_low_after_start: got 0 required 1"); end
    n_chk++; if (done_at !== lat) begin n_fail++; $display("FAIL done_latency: got %0d required %0d", done_at, lat); end
    n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL done_pulses: got %0d required 1", done_cnt); end
    n_chk++; if (!rise_ok) begin n_fail++; $display("FAIL ss_rise_with_done: got 0 required 1"); end
    n_chk++; if (torn) begin n_fail++; $display("FAIL data_held_during_burst: data changed before done"); end
    n_chk++; if (cur_data(sel) !== exp_data) begin n_fail++; $display("FAIL data_flat: got %h required %h", cur_data(sel), exp_data); end
    n_chk++; if ((sel ? err_d : err_a) !== exp_err) begin n_fail++; $display("FAIL chk_err: got %b required %b", sel ? err_d : err_a, exp_err); end
    n_chk++; if ((sel ? rd : ra) !== c) begin n_fail++; $display("FAIL mosi_cmd: got %h required %h", sel ? rd : ra, c); end
    n_chk++; if (cyc !== lat + gap) begin n_fail++; $display("FAIL busy_fall_cycle: got %0d required %0d", cyc, lat + gap); end
    n_chk++; if (ss_hi < gap) begin n_fail++; $display("FAIL ss_gap: got %0d required >= %0d", ss_hi, gap); end
  endtask

  task automatic burst_a(input logic [7:0] c, input logic [31:0] w, input bit bad, input int p1, input int p2);
    logic [31:0] nd, ex;
    bit e;
    load_a(w, bad, nd);
    e  = (CHK == 1) && bad;
    ex = e ? model_a : nd;
    run_burst(1'b0, c, {112'b0, ex}, e, {112'b0, model_a}, p1, p2);
    model_a = ex;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_chk++; if (ss_a !== 1'b1 || sck_a !== 1'b0 || mosi_a !== 1'b0) begin n_fail++; $display("FAIL reset_pins: ss=%b sck=%b mosi=%b required 1 0 0", ss_a, sck_a, mosi_a); end
    n_chk++; if (busy_a !== 1'b0 || done_a !== 1'b0 || err_a !== 1'b0) begin n_fail++; $display("FAIL reset_flags: busy=%b done=%b err=%b required 0", busy_a, done_a, err_a); end
    n_chk++; if (data_a !== 32'h0 || data_d !== 144'h0) begin n_fail++; $display("FAIL reset_data: got %h / %h required 0", data_a, data_d); end
    n_chk++; if (ss_d !== 1'b1 || busy_d !== 1'b0) begin n_fail++; $display("FAIL reset_default_inst: ss=%b busy=%b", ss_d, busy_d); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic;
    burst_a(8'h3A, 32'h1234_ABCD, 1'b0, 0, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_ignore_start;
    burst_a(8'hC5, 32'h0F0F_5AA5, 1'b0, 10, latency(2, CD_A) + 2);
    repeat (5) @(negedge clock);
    n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL start_not_queued: busy=%b required 0", busy_a); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 5; i++) begin
      burst_a(8'($urandom), $urandom, 1'($urandom_range(0, 1)), 0, 0);
      repeat (1 + $urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  task automatic test_checksum;
    burst_a(8'h3A, 32'h1234_ABCD, 1'b0, 0, 0);
    repeat (2) @(negedge clock);
    burst_a(8'h3B, 32'h1122_3344, 1'b1, 0, 0);
    repeat (2) @(negedge clock);
    burst_a(8'h3C, 32'h5566_7788, 1'b0, 0, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_default_params;
    logic [143:0] ex;
    logic [7:0] s;
    s = 8'h00;
    ex = '0;
    qd.delete();
    qd.push_back(8'h00);
    for (int i = 0; i < 18; i++) begin qd.push_back(8'(i)); s = s + 8'(i); end
    qd.push_back(s);
    for (int k = 0; k < 9; k++) ex[k*16 +: 16] = {8'(2*k), 8'(2*k + 1)};
    run_burst(1'b1, 8'h9E, ex, 1'b0, model_d, 0, 0);
    model_d = ex;
    n_chk++; if (data_d[8*16 +: 16] !== 16'h1011) begin n_fail++; $display("FAIL accel_ch8: got %h required 1011", data_d[8*16 +: 16]); end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_burst;
    cmd = 8'h77;
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    for (int k = 1; k < 50; k++) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    start_a = 1'b1;
    @(negedge clock);
    n_chk++; if (ss_a !== 1'b1 || sck_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pins: ss=%b sck=%b required 1 0", ss_a, sck_a); end
    n_chk++; if (data_a !== 32'h0 || data_d !== 144'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h / %h required 0", data_a, data_d); end
    n_chk++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL mid_reset_wins: busy=%b done=%b required 0", busy_a, done_a); end
    reset = 1'b1;
    start_a = 1'b0;
    model_a = '0;
    model_d = '0;
    repeat (2) @(negedge clock);
    burst_a(8'h42, 32'hDEAD_BEEF, 1'b0, 0, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back;
    burst_a(8'hA1, 32'h0102_0304, 1'b0, 0, 0);
    burst_a(8'hA2, 32'hF0E0_D0C0, 1'b0, 0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_random();
    test_checksum();
    test_default_params();
    test_reset_mid_burst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
